// File: rtl/pc_stack.sv
// pc_stack: program counter with a LIFO return-address stack and optional sticky ovf/unf flags.
//
// Parameters
//   WIDTH  program-counter / address width in bits (>= 4)
//   DEPTH  return-stack entries (>= 2, power of two)
//   STEP   increment used by inc and by the call return address
//
// Ports
//   CLK       rising-edge clock
//   reset_n   asynchronous active-low reset
//   in        absolute target for load and call
//   offset    two's-complement displacement for rel
//   load, rel, inc, call, ret   requests, priority ret > call > load > rel > inc
//   err_clr   clears sticky ovf/unf (an event in the same cycle wins)
//   out       registered program counter
//   top       top-of-stack entry, 0 when empty
//   level     number of valid stack entries
//   empty, full   level==0 / level==DEPTH
//   ovf, unf  sticky overflow (call while full) / underflow (ret while empty)
//
// Define PC_STACK_ERR_EN to build the sticky flags; otherwise ovf/unf are 0
// and err_clr is ignored.
module pc_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP = 1
) (
  input  logic                     CLK,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in,
  input  logic [WIDTH-1:0]         offset,
  input  logic                     load,
  input  logic                     rel,
  input  logic                     inc,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         out,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  output logic                     unf
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [WIDTH-1:0] ret_addr, nxt_out;
  logic push, pop, ovf_ev, unf_ev;
  // Low bits of level address the next free slot; at level==DEPTH they wrap
  // to 0, so wp-1 still points at the last entry.
  assign wp = level[AW-1:0];
  assign ret_addr = out + WIDTH'(STEP);
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign top = empty ? '0 : mem[wp - 1'b1];
  assign pop = ret & ~empty;
  assign push = ~ret & call & ~full;
  assign unf_ev = ret & empty;
  assign ovf_ev = ~ret & call & full;
  always_comb begin
    nxt_out = ret ? (empty ? ret_addr : top) :
              call ? in :
              load ? in :
              rel ? out + offset :
              inc ? ret_addr : out;
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      level <= '0;
    end else begin
      out <= nxt_out;
      level <= push ? level + 1'b1 : pop ? level - 1'b1 : level;
    end
  end
  // Storage is not reset; validity is carried by level alone.
  always_ff @(posedge CLK) begin
    if (push && reset_n) mem[wp] <= ret_addr;
  end
`ifdef PC_STACK_ERR_EN
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_ev | (ovf & ~err_clr);
      unf <= unf_ev | (unf & ~err_clr);
    end
  end
`else
  logic unused_err;
  assign unused_err = err_clr | ovf_ev | unf_ev;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed self-checking bench for pc_stack (WIDTH=16, DEPTH=8, STEP=1).
module tb_pc_stack;
  logic CLK = 1'b0, reset_n = 1'b0;
  logic [15:0] in = '0, offset = '0;
  logic load = 0, rel = 0, inc = 0, call = 0, ret = 0, err_clr = 0;
  logic [15:0] out, top;
  logic [3:0] level;
  logic empty, full, ovf, unf;
  int n_chk = 0, n_err = 0;
`ifdef PC_STACK_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif
  logic [15:0] exp_q [$];

  pc_stack #(.WIDTH(16), .DEPTH(8), .STEP(1)) dut (
    .CLK(CLK), .reset_n(reset_n), .in(in), .offset(offset),
    .load(load), .rel(rel), .inc(inc), .call(call), .ret(ret), .err_clr(err_clr),
    .out(out), .top(top), .level(level), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {load, rel, inc, call, ret, err_clr} = '0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    idle();
  endtask

  initial begin
    #12;
    chk("rst_out", out, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_top", top, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_unf", unf, 0);
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      inc = 1; cyc();
      chk("inc", out, i);
    end
    load = 1; in = 16'h0100; cyc();
    chk("load", out, 16'h0100);
    cyc();
    chk("hold", out, 16'h0100);
    load = 1; in = 16'h0010; cyc();
    call = 1; in = 16'h0200; cyc();
    chk("call_out", out, 16'h0200);
    chk("call_top", top, 16'h0011);
    chk("call_level", level, 1);
    ret = 1; cyc();
    chk("ret_out", out, 16'h0011);
    chk("ret_level", level, 0);
    chk("ret_empty", empty, 1);
    exp_q = {};
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(out + 16'd1);
      call = 1; in = 16'h1000 + 16'(i * 16); cyc();
    end
    chk("nine_out", out, 16'h1080);
    chk("nine_level", level, 8);
    chk("nine_full", full, 1);
    chk("nine_ovf", ovf, EE);
    chk("nine_top", top, 16'h1061);
    for (int i = 0; i < 8; i++) begin
      ret = 1; cyc();
      chk("pop_out", out, exp_q.pop_back());
    end
    chk("pop_empty", empty, 1);
    chk("ovf_sticky", ovf, EE);
    err_clr = 1; cyc();
    chk("ovf_clr", ovf, 0);
    load = 1; in = 16'h0005; cyc();
    ret = 1; cyc();
    chk("unf_out", out, 16'h0006);
    chk("unf_level", level, 0);
    chk("unf_flag", unf, EE);
    err_clr = 1; cyc();
    chk("unf_clr", unf, 0);
    chk("unf_clr_out", out, 16'h0006);
    err_clr = 1; ret = 1; cyc();
    chk("unf_win", unf, EE);
    chk("unf_win_out", out, 16'h0007);
    load = 1; in = 16'hFFFF; cyc();
    inc = 1; cyc();
    chk("wrap", out, 16'h0000);
    load = 1; in = 16'h0003; cyc();
    rel = 1; offset = 16'hFFFE; cyc();
    chk("rel_neg", out, 16'h0001);
    rel = 1; inc = 1; offset = 16'h0004; cyc();
    chk("rel_over_inc", out, 16'h0005);
    call = 1; in = 16'h0300; cyc();
    chk("pre_prio_top", top, 16'h0006);
    call = 1; ret = 1; load = 1; in = 16'h0400; cyc();
    chk("prio_out", out, 16'h0006);
    chk("prio_level", level, 0);
    load = 1; in = 16'h0020; cyc();
    call = 1; in = 16'h0500; cyc();
    chk("pre_rst_level", level, 1);
    call = 1; in = 16'h0600;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_level", level, 0);
    chk("arst_unf", unf, 0);
    @(negedge CLK);
    idle();
    reset_n = 1'b1;
    cyc();
    chk("post_level", level, 0);
    chk("post_top", top, 0);
    chk("post_out", out, 0);
    ret = 1; cyc();
    chk("post_ret", out, 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16, is the program-counter and address width in bits (min 4).
REQ-002 Parameter DEPTH, default 8, is the number of return-stack entries (min 2, power of two).
REQ-003 Parameter STEP, default 1, is the increment added by inc and by call return-address computation.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  WIDTH  absolute target for load and call.
REQ-007 offset  input  WIDTH  two's-complement displacement for rel.
REQ-008 load, rel, inc, call, ret  input  1 each  operation requests.
REQ-009 err_clr  input  1  clears sticky error flags.
REQ-010 out  output  WIDTH  registered program counter.
REQ-011 top  output  WIDTH  current top-of-stack entry, combinational from stack state; 0 when empty.
REQ-012 level  output  clog2(DEPTH)+1  number of valid stack entries.
REQ-013 empty, full  output  1 each  level==0 and level==DEPTH, combinational.
REQ-014 ovf, unf  output  1 each  sticky overflow and underflow flags.

Function
REQ-015 One operation per cycle, chosen by fixed priority: ret > call > load > rel > inc > hold.
REQ-016 ret, not empty: out <= top; level decrements by 1; latency one cycle.
REQ-017 ret, empty: out <= out+STEP; level stays 0; unf event raised.
REQ-018 call, not full: push out+STEP; out <= in; level increments by 1.
REQ-019 call, full: out <= in; push dropped; stack contents and level unchanged; ovf event raised.
REQ-020 load: out <= in.
REQ-021 rel: out <= out+offset.
REQ-022 inc: out <= out+STEP.
REQ-023 No request asserted: out, stack and level hold.
REQ-024 All arithmetic is modulo 2^WIDTH; wrap-around from all-ones to zero is silent and raises no flag.
REQ-025 A lower-priority request asserted with a higher-priority one is ignored for that cycle, with no side effect.
REQ-026 Stack is LIFO; entries below top are never modified by ret.
REQ-027 err_clr clears ovf/unf at the clock edge; an ovf/unf event in the same cycle wins, and the flag is set.

Reset
REQ-028 reset_n low asynchronously forces out=0, level=0, ovf=0, unf=0, and marks all stack entries invalid.
REQ-029 Stack RAM contents are don't-care after reset; top reads 0 while empty.
REQ-030 Reset asserted mid-operation aborts it; no partial push or pop survives.
REQ-031 First operation executes on the first rising CLK edge after reset_n deasserts.

Configuration
REQ-032 Macro PC_STACK_ERR_EN compiles in the ovf/unf sticky flags and err_clr handling.
REQ-033 With PC_STACK_ERR_EN defined, ovf/unf behave per REQ-017, REQ-019 and REQ-027.
REQ-034 Without PC_STACK_ERR_EN, ovf and unf are tied 0 and err_clr is ignored; all PC and stack behaviour is identical.

Verification
REQ-035 Reset then inc x3 (STEP=1) -> out 0,1,2,3; load in=0x0100 -> out=0x0100; hold -> 0x0100 persists.
REQ-036 out=0x0010; call in=0x0200 -> out=0x0200, top=0x0011, level=1; ret -> out=0x0011, level=0, empty=1.
REQ-037 Nine calls with DEPTH=8 -> level=8, full=1; ninth jump taken; ovf=1 (ERR_EN); eight rets return addresses in reverse order.
REQ-038 ret when empty at out=0x0005 -> out=0x0006, level=0, unf=1; err_clr -> unf=0; err_clr with simultaneous empty ret -> unf stays 1.
REQ-039 out=0xFFFF inc -> 0x0000; out=0x0003 rel offset=0xFFFE -> 0x0001; call+ret+load together -> only ret executes.
REQ-040 reset_n pulsed low between clock edges during call -> out=0, level=0 immediately; stack push not retained after release.
